hazard_scoreboard: RTL

Parametrised successor to the single-cycle ID-stage interlock. It tracks every in-flight register write with a per-register countdown, so producers of any latency (ALU, load, multiply) are interlocked exactly as long as needed and no longer. It sits in decode: it sees the instruction being issued and drives the `stall`/`IFID_Write`/`PCWrite` controls to the fetch and ID/EX registers. It also interlocks write-after-write hazards and writeback-port collisions, which the two-stage comparator does not.

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/hazard_scoreboard_counter.sv | 36 +++
 rtl/hazard_scoreboard.sv | 115 +++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the decode-stage hazard scoreboard.
//   lat_t              : latency field for the default MAX_LAT of 4
//   SC_RAW/SC_WAW/SC_WBC : bit positions inside stall_cause
//   LAT_ALU/LAT_LOAD/LAT_MUL : producer latencies of the standard units
package hazard_pkg;

   localparam int MAX_LAT_DEF = 4;
   localparam int LAT_W_DEF   = $clog2(MAX_LAT_DEF + 1);

   typedef logic [LAT_W_DEF-1:0] lat_t;

   localparam int SC_RAW = 0;
   localparam int SC_WAW = 1;
   localparam int SC_WBC = 2;

   localparam lat_t LAT_ALU  = lat_t'(1);
   localparam lat_t LAT_LOAD = lat_t'(2);
   localparam lat_t LAT_MUL  = lat_t'(3);

endpackage

// File: rtl/hazard_scoreboard_counter.sv
// reg_pend_counter: per-register countdown of cycles until the register is
// forwardable. Loads a new value on issue, otherwise counts down to 0 and holds.
//   clk, rst  : clock, synchronous active-high reset
//   load      : an issuing instruction targets this register
//   load_val  : value to load (effective latency minus one)
//   cnt       : cycles remaining, 0 = ready
module reg_pend_counter
   import hazard_pkg::*;
#(
   parameter int LAT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [LAT_W-1:0] load_val,
   output logic [LAT_W-1:0] cnt
);

   logic [LAT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = load_val;
      else if (cnt_q != '0)
         cnt_d = cnt_q - LAT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: decode-stage interlock for multi-latency producers.
// Tracks a countdown per register and a write-port reservation shift register,
// and stalls ID on RAW, WAW or writeback-port conflicts.
//   clk, rst                 : clock, synchronous active-high reset
//   issue_valid, flush       : instruction present in ID / squashed this cycle
//   rd_mask, rd_num          : used read ports and their source registers
//   wr_en, wr_num, wr_lat    : destination write and its producer latency
//   stall, IFID_Write, PCWrite : pipeline hold controls
//   stall_cause              : one-hot {wbc, waw, raw}, RAW has priority
//   issued                   : instruction leaves ID this cycle
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int NUM_REGS = 16,
   parameter int NUM_RD   = 3,
   parameter int MAX_LAT  = 4,
   parameter int REG_W    = $clog2(NUM_REGS),
   parameter int LAT_W    = $clog2(MAX_LAT + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              issue_valid,
   input  logic              flush,
   input  logic [NUM_RD-1:0] rd_mask,
   input  logic [REG_W-1:0]  rd_num [NUM_RD],
   input  logic              wr_en,
   input  logic [REG_W-1:0]  wr_num,
   input  logic [LAT_W-1:0]  wr_lat,
   output logic              stall,
   output logic              IFID_Write,
   output logic              PCWrite,
   output logic [2:0]        stall_cause,
   output logic              issued
);

   logic [LAT_W-1:0]    pend [NUM_REGS];
   logic [NUM_REGS-1:0] pend_load;
   logic [MAX_LAT-1:0]  wb_busy_q, wb_busy_d;
   logic [LAT_W-1:0]    eff_lat, eff_lat_m1, pend_wr;
   logic                raw, waw, wbc, hazard;

   // Effective latency: 0 behaves as 1, anything above MAX_LAT saturates.
   always_comb begin
      eff_lat = wr_lat;
      if (wr_lat == '0)
         eff_lat = LAT_W'(1);
      else if (int'(wr_lat) > MAX_LAT)
         eff_lat = LAT_W'(MAX_LAT);
      eff_lat_m1 = eff_lat - LAT_W'(1);
   end

   // Hazard checks against current state only; a read of the instruction's
   // own destination sees the old countdown.
   always_comb begin
      raw     = 1'b0;
      pend_wr = '0;
      wbc     = 1'b0;
      for (int i = 0; i < NUM_RD; i++)
         for (int r = 0; r < NUM_REGS; r++)
            if (rd_mask[i] && rd_num[i] == REG_W'(r) && pend[r] != '0)
               raw = 1'b1;
      for (int r = 0; r < NUM_REGS; r++)
         if (wr_num == REG_W'(r))
            pend_wr = pend[r];
      for (int k = 0; k < MAX_LAT; k++)
         if (int'(eff_lat) == k + 1 && wb_busy_q[k])
            wbc = 1'b1;
      waw    = wr_en && (pend_wr > eff_lat_m1);
      wbc    = wr_en && wbc;
      hazard = raw || waw || wbc;
   end

   always_comb begin
      stall       = rst | (issue_valid & ~flush & hazard);
      issued      = issue_valid & ~stall & ~flush;
      IFID_Write  = ~stall;
      PCWrite     = ~stall;
      stall_cause = '0;
      if (!rst && stall) begin
         if (raw)      stall_cause[SC_RAW] = 1'b1;
         else if (waw) stall_cause[SC_WAW] = 1'b1;
         else          stall_cause[SC_WBC] = 1'b1;
      end
   end

   always_comb begin
      for (int r = 0; r < NUM_REGS; r++)
         pend_load[r] = issued && wr_en && (wr_num == REG_W'(r));
   end

   // Write-port reservation: bit k = port taken k+1 cycles from now. A new
   // producer of latency L claims bit L-2 after this cycle's shift.
   always_comb begin
      wb_busy_d = wb_busy_q >> 1;
      for (int k = 0; k < MAX_LAT; k++)
         if (issued && wr_en && int'(eff_lat) == k + 2)
            wb_busy_d[k] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) wb_busy_q <= '0;
      else     wb_busy_q <= wb_busy_d;
   end

   for (genvar r = 0; r < NUM_REGS; r++) begin : g_pend
      reg_pend_counter #(.LAT_W(LAT_W)) u_cnt (
         .clk      (clk),
         .rst      (rst),
         .load     (pend_load[r]),
         .load_val (eff_lat_m1),
         .cnt      (pend[r])
      );
   end

endmodule
